// File: rtl/fft8_pkg.sv
`default_nettype none
// ==[ fft8_pkg ]== shared constants, types and helpers for the 8-point FFT frame controller
// ==[ rev 1.0 ]==
package fft8_pkg;

  localparam int NPTS     = 8;
  localparam int IDX_W    = 3;
  localparam int LAST_IDX = NPTS - 1;
  // Sample width at the default N; modules size their ports from their own N.
  localparam int SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t re;
    sample_t im;
  } cbin_t;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_PEND    = 1'b1
  } in_state_t;

  function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  function automatic int frame_w(input int w);
    return NPTS * w;
  endfunction

  function automatic int slot_lsb(input int slot, input int w);
    return slot * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft8_res_buf.sv
`default_nettype none
// ==[ fft8_res_buf ]== circular buffer of RES_DEPTH result frames with per-slot combinational read
// ==[ rev 1.0 ]==
module fft8_res_buf
  import fft8_pkg::*;
#(
  parameter int W         = 16,
  parameter int RES_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  logic [NPTS*W-1:0]                  push_re,
  input  logic [NPTS*W-1:0]                  push_im,
  input  logic                               pop,
  input  logic [IDX_W-1:0]                   rd_slot,
  output logic [W-1:0]                       rd_re,
  output logic [W-1:0]                       rd_im,
  output logic [$clog2(RES_DEPTH+1)-1:0]     count
);

  localparam int FW = NPTS * W;
  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CW = $clog2(RES_DEPTH + 1);

  logic [FW-1:0] mem_re [RES_DEPTH];
  logic [FW-1:0] mem_im [RES_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // The launch credit check upstream must make this unreachable.
      a_no_overflow: assert (!(push && count == CW'(RES_DEPTH)));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_re[wr_ptr] <= push_re;
      mem_im[wr_ptr] <= push_im;
    end
  end

  assign rd_re = mem_re[rd_ptr][slot_lsb(int'(rd_slot), W) +: W];
  assign rd_im = mem_im[rd_ptr][slot_lsb(int'(rd_slot), W) +: W];

endmodule
`default_nettype wire

// File: rtl/fft8_frame_ctrl.sv
`default_nettype none
// ==[ fft8_frame_ctrl ]== packs samples into frames, launches/captures the FFT datapath, serializes bins
// ==[ rev 1.0 ]==
module fft8_frame_ctrl
  import fft8_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int PIPE_LAT  = 6,
  parameter  int RES_DEPTH = 2,
  parameter  int BITREV    = 1,
  localparam int W         = 2**N
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  output logic [NPTS*W-1:0]   fft_in,
  output logic                fft_launch,
  input  logic [NPTS*W-1:0]   fft_res_re,
  input  logic [NPTS*W-1:0]   fft_res_im,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_re,
  output logic [W-1:0]        out_im,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last,
  output logic                busy
);

  localparam int CW = $clog2(RES_DEPTH + 1);

  in_state_t            state, state_nxt;
  logic [IDX_W-1:0]     wr_idx;
  logic [IDX_W-1:0]     rd_idx;
  logic [CW-1:0]        inflight;
  logic [CW-1:0]        buf_count;
  logic [PIPE_LAT-1:0]  lat_sr;
  logic                 credit, capture, accept, pop;
  logic [IDX_W-1:0]     rd_slot;
  logic [W-1:0]         rd_re, rd_im;

  // Credit counts frames in the datapath as already occupying buffer space.
  assign credit  = ({1'b0, inflight} + {1'b0, buf_count}) < (CW+1)'(RES_DEPTH);
  assign capture = lat_sr[PIPE_LAT-1];
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    fft_launch = 1'b0;
    if (!rst) begin
      case (state)
        ST_COLLECT: begin
          in_ready = 1'b1;
          if (in_valid && wr_idx == IDX_W'(LAST_IDX)) state_nxt = ST_PEND;
        end
        ST_PEND: begin
          if (credit) begin
            fft_launch = 1'b1;
            state_nxt  = ST_COLLECT;
          end
        end
        default: state_nxt = ST_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx   <= '0;
      fft_in   <= '0;
      lat_sr   <= '0;
      inflight <= '0;
      rd_idx   <= '0;
    end else begin
      if (accept) begin
        fft_in[slot_lsb(int'(wr_idx), W) +: W] <= in_data;
        wr_idx <= wr_idx + 1'b1;
      end else if (fft_launch) begin
        wr_idx <= '0;
      end
      lat_sr <= (lat_sr << 1) | PIPE_LAT'(fft_launch);
      case ({fft_launch, capture})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (out_valid && out_ready) rd_idx <= rd_idx + 1'b1;
    end
  end

  assign pop     = out_valid && out_ready && (rd_idx == IDX_W'(LAST_IDX));
  assign rd_slot = (BITREV != 0) ? bitrev3(rd_idx) : rd_idx;

  fft8_res_buf #(
    .W         (W),
    .RES_DEPTH (RES_DEPTH)
  ) u_res_buf (
    .clk     (clk),
    .rst     (rst),
    .push    (capture),
    .push_re (fft_res_re),
    .push_im (fft_res_im),
    .pop     (pop),
    .rd_slot (rd_slot),
    .rd_re   (rd_re),
    .rd_im   (rd_im),
    .count   (buf_count)
  );

  assign out_valid = (buf_count != '0);
  assign out_re    = out_valid ? rd_re : '0;
  assign out_im    = out_valid ? rd_im : '0;
  assign out_idx   = rd_idx;
  assign out_last  = out_valid && (rd_idx == IDX_W'(LAST_IDX));
  assign busy      = (state == ST_PEND) || (wr_idx != '0) || (inflight != '0) || (buf_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_fft8_frame_ctrl.sv
`default_nettype none
// ==[ tb_fft8_frame_ctrl ]== random frames through a bit-reversing datapath model, checked against a DFT reference
// ==[ rev 1.0 ]==
module tb_fft8_frame_ctrl;

  localparam int W  = 16;
  localparam int FW = 8 * W;
  localparam int PL = 8;
  localparam int RD = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid, in_ready, fft_launch, out_valid, out_ready, out_last, busy;
  logic [W-1:0]   in_data, out_re, out_im;
  logic [FW-1:0]  fft_in, fft_res_re, fft_res_im;
  logic [2:0]     out_idx;

  int tests = 0;
  int fails = 0;
  int launches = 0;
  int dp_mode = 0;
  int ready_mode = 1;
  logic tog = 1'b0;

  logic [FW-1:0]   hre [PL];
  logic [FW-1:0]   him [PL];
  logic [2*FW-1:0] dp_t;
  logic [W-1:0]    part   [$];
  logic [W-1:0]    exp_re [$];
  logic [W-1:0]    exp_im [$];
  logic [2:0]      exp_k  [$];
  logic [W-1:0]    rev_tab [8] = '{16'd10, 16'd14, 16'd12, 16'd16, 16'd11, 16'd15, 16'd13, 16'd17};

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;
  assign out_ready = (ready_mode == 2) ? tog : (ready_mode == 1);

  fft8_frame_ctrl #(
    .N         (4),
    .PIPE_LAT  (PL),
    .RES_DEPTH (RD),
    .BITREV    (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .fft_in     (fft_in),
    .fft_launch (fft_launch),
    .fft_res_re (fft_res_re),
    .fft_res_im (fft_res_im),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .busy       (busy)
  );

  function automatic logic [2:0] rev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
  endfunction

  // Rounded 8-point DFT bin k of a frame: {re, im}.
  function automatic logic [2*W-1:0] dft_bin(input logic [FW-1:0] f, input int k);
    real sr, si, th, x;
    sr = 0.0;
    si = 0.0;
    for (int n = 0; n < 8; n++) begin
      th = 2.0 * 3.14159265358979 * real'(k * n) / 8.0;
      x  = real'($signed(f[n*W +: W]));
      sr = sr + x * $cos(th);
      si = si - x * $sin(th);
    end
    return {W'(rnd(sr)), W'(rnd(si))};
  endfunction

  // Datapath model: bin k emerges in slot rev3(k); mode 1 emits re = slot + 10.
  function automatic logic [2*FW-1:0] dp_out(input logic [FW-1:0] f, input int mode);
    logic [FW-1:0]  r, i;
    logic [2*W-1:0] b;
    r = '0;
    i = '0;
    for (int s = 0; s < 8; s++) begin
      if (mode == 1) begin
        r[s*W +: W] = W'(s + 10);
      end else begin
        b = dft_bin(f, int'(rev3(3'(s))));
        r[s*W +: W] = b[2*W-1:W];
        i[s*W +: W] = b[W-1:0];
      end
    end
    return {r, i};
  endfunction

  assign dp_t = dp_out(fft_in, dp_mode);

  always @(posedge clk) begin
    for (int i = PL - 1; i > 0; i--) begin
      hre[i] <= hre[i-1];
      him[i] <= him[i-1];
    end
    hre[0] <= dp_t[2*FW-1:FW];
    him[0] <= dp_t[FW-1:0];
  end

  assign fft_res_re = hre[PL-1];
  assign fft_res_im = him[PL-1];

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [FW-1:0]  frame;
    logic [2*W-1:0] b;
    forever begin
      @(negedge clk);
      if (rst) begin
        part.delete();
        exp_re.delete();
        exp_im.delete();
        exp_k.delete();
      end else begin
        if (fft_launch) launches++;
        if (in_valid && in_ready) begin
          part.push_back(in_data);
          if (part.size() == 8) begin
            for (int n = 0; n < 8; n++) frame[n*W +: W] = part[n];
            for (int k = 0; k < 8; k++) begin
              if (dp_mode == 1) begin
                exp_re.push_back(rev_tab[k]);
                exp_im.push_back('0);
              end else begin
                b = dft_bin(frame, k);
                exp_re.push_back(b[2*W-1:W]);
                exp_im.push_back(b[W-1:0]);
              end
              exp_k.push_back(3'(k));
            end
            part.delete();
          end
        end
        if (out_valid) begin
          if (exp_re.size() == 0) begin
            chk("spurious_out_valid", out_valid, 1'b0);
          end else begin
            chk("bin_re", out_re, exp_re[0]);
            chk("bin_im", out_im, exp_im[0]);
            chk("bin_idx", out_idx, exp_k[0]);
            chk("bin_last", out_last, exp_k[0] == 3'd7);
            if (out_ready) begin
              void'(exp_re.pop_front());
              void'(exp_im.pop_front());
              void'(exp_k.pop_front());
            end
          end
        end
      end
    end
  endtask

  task automatic send(input logic [W-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) chk("send_timeout", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [FW-1:0] f);
    for (int n = 0; n < 8; n++) send(f[n*W +: W]);
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int n = 0; n < 8; n++) f[n*W +: W] = W'(int'($urandom_range(0, 2000)) - 1000);
    return f;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while ((busy || exp_re.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    chk("drain_busy", busy, 1'b0);
    chk("drain_queue", exp_re.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int   lat;
    int   base;
    logic seen;
    in_valid = 1'b0;
    in_data  = '0;
    fork
      monitor();
    join_none

    repeat (2) tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_launch", fft_launch, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_idx", out_idx, 3'd0);
    chk("rst_fft_in", fft_in, '0);
    chk("rst_out_re", out_re, '0);
    chk("rst_out_im", out_im, '0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1'b1);

    // Impulse frame and first-bin latency.
    send_frame(FW'(1));
    chk("launch_after_slot7", fft_launch, 1'b1);
    chk("pend_in_ready", in_ready, 1'b0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("first_bin_latency", lat, PL + 2);
    chk("impulse_bin0_re", out_re, 16'd1);
    chk("impulse_bin0_im", out_im, 16'd0);
    chk("impulse_bin0_idx", out_idx, 3'd0);
    drain();

    // Slot-tagged datapath exposes the bit-reversed read order.
    dp_mode = 1;
    send_frame(rand_frame());
    drain();
    dp_mode = 0;

    repeat (5) send_frame(rand_frame());
    drain();

    // Backpressure: only RES_DEPTH frames may launch while output is stalled.
    ready_mode = 0;
    base = launches;
    repeat (3) send_frame(rand_frame());
    repeat (30) tick();
    chk("bp_launches", launches - base, RD);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    chk("bp_busy", busy, 1'b1);
    ready_mode = 1;
    send_frame(rand_frame());
    drain();
    chk("bp_total_launches", launches - base, 4);

    // Toggling ready against a steady input stream.
    ready_mode = 2;
    repeat (8) send_frame(rand_frame());
    drain();
    ready_mode = 1;

    // Reset with 5 samples collected and one frame in flight.
    send_frame(rand_frame());
    repeat (5) send(W'($urandom_range(0, 500)));
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_in_ready", in_ready, 1'b1);
    seen = 1'b0;
    repeat (PL + 4) begin
      tick();
      seen = seen | out_valid;
    end
    chk("no_stale_out_valid", seen, 1'b0);
    send_frame(rand_frame());
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
